dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance edge to rsp_valid high (1..8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  processor presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port req_wdata  input  32  store data, LSBs used for B/H.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  processor consumes response.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned, out-of-range or illegal funct3.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid && req_ready, latching we, addr, funct3, wdata.
REQ-017 SHALL go IDLE->RESP on acceptance when LATENCY=1, else IDLE->WAIT with latency counter loaded to LATENCY-2.
REQ-018 SHALL decrement the counter each WAIT cycle and go WAIT->RESP when it reads 0, so rsp_valid rises exactly LATENCY cycles after acceptance.
REQ-019 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready; RESP->IDLE on rsp_valid && rsp_ready.
REQ-020 SHALL NOT accept a new request in the cycle the response is consumed (req_ready rises the following cycle).
REQ-021 SHALL flag error when: funct3 in {011,110,111}; H/HU/SH with addr[0]=1; W with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
REQ-022 SHALL commit a legal store on the acceptance edge via byte enables (SB 1 lane, SH 2 lanes, SW 4 lanes, lane chosen by addr[1:0]); an erroring store SHALL write nothing.
REQ-023 SHALL capture load data on entry to RESP: B/H sign-extended, BU/HU zero-extended, W unmodified, byte/halfword selected by addr[1:0].
REQ-024 SHALL treat a read following a store to the same word as returning the newly written data.
REQ-025 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-026 SHALL on rst force state IDLE, counter 0, req_ready 1 after the reset cycle, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-027 SHALL abort any in-flight request on rst mid-operation with no response; a store already committed at acceptance SHALL remain.
REQ-028 SHALL NOT clear memory contents on reset.

Structure
REQ-029 SHALL place funct3 encodings (LB..LHU) and the state enum in shared package dmem_pkg.
REQ-030 SHALL use one sub-module dmem_array: DEPTH_WORDS x 32 storage, 4-bit byte-enable write, combinational word read.

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=2) -> rsp_valid 2 cycles after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-032 After REQ-031, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-033 SH 0x1234 @0x11 -> err 1, rdata 0, word @0x10 still 0xDEADBEEF; LW @0x12 -> err 1.
REQ-034 LW @ (DEPTH_WORDS*4) -> err 1; funct3=011 -> err 1; req_ready 0 throughout WAIT/RESP.
REQ-035 Hold rsp_ready 0 for 5 cycles in RESP -> rsp_valid/rdata stable; rsp_ready 1 -> IDLE next cycle, req_ready 1.
REQ-036 Assert rst during WAIT of a load -> rsp_valid never rises, next cycle IDLE with req_ready 1; prior stores intact.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32I load/store width codes (funct3)
//   - FSM state encoding
//   - helpers: access legality, store byte enables, load extension
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Illegal width code, misalignment for the access size, or word index
  // beyond the array.
  function automatic logic access_err(input logic [2:0]  f3,
                                      input logic [31:0] addr,
                                      input int unsigned depth_words);
    logic e;
    e = 1'b0;
    case (f3)
      F3_LB, F3_LBU: e = 1'b0;
      F3_LH, F3_LHU: e = addr[0];
      F3_LW:         e = (addr[1:0] != 2'b00);
      default:       e = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= depth_words) e = 1'b1;
    return e;
  endfunction

  // Store size comes from funct3[1:0]; lane position from the low address bits.
  function automatic logic [3:0] byte_en(input logic [2:0] f3,
                                         input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {a, 3'b000};
    case (f3)
      F3_LB:   r = {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  r = {24'h0, sh[7:0]};
      F3_LH:   r = {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  r = {16'h0, sh[15:0]};
      F3_LW:   r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and combinational read.
//   clk_i   : clock
//   we_i    : write strobe
//   be_i    : byte lane enables
//   waddr_i : write word index
//   wdata_i : write data (lane-aligned)
//   raddr_i : read word index
//   rdata_o : read data (combinational)
// Contents are not reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i && be_i[l]) mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_resp.sv
// Fixed-latency data-memory responder for an RV32I load/store port.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (accepted only in IDLE)
//   req_we/addr/funct3/wdata: request payload
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata, rsp_err      : extended load data / access error
//   dbg_state_o             : current FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
// Stores commit on the acceptance edge; the response only acknowledges them.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [2:0]  cur_f3;
  logic        cur_err;
  logic [31:0] mem_rdata;
  logic [31:0] store_data;

  assign accept = req_valid && (state_q == ST_IDLE);

  // In IDLE the live request is the one being evaluated (store commit, and
  // the load capture when LATENCY is 1); otherwise the latched copy is.
  assign cur_we   = (state_q == ST_IDLE) ? req_we     : we_q;
  assign cur_addr = (state_q == ST_IDLE) ? req_addr   : addr_q;
  assign cur_f3   = (state_q == ST_IDLE) ? req_funct3 : f3_q;
  assign cur_err  = access_err(cur_f3, cur_addr, DEPTH_WORDS);

  // Replicate the low byte/halfword so every enabled lane sees its data.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   store_data = {4{req_wdata[7:0]}};
      2'b01:   store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i   (clk),
    .we_i    (accept && req_we && !cur_err),
    .be_i    (byte_en(req_funct3, req_addr[1:0])),
    .waddr_i (req_addr[AW+1:2]),
    .wdata_i (store_data),
    .raddr_i (cur_addr[AW+1:2]),
    .rdata_o (mem_rdata)
  );

  assign enter_resp = (accept && (LATENCY == 1)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 3'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_we || cur_err) ? 32'h0
                                    : load_extend(cur_f3, cur_addr[1:0], mem_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q   <= req_we;
        addr_q <= req_addr;
        f3_q   <= req_funct3;
      end
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int WIN   = 16;  // words exercised by random traffic

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];          // {err, rdata}
  logic [7:0]  mem_m [DEPTH*4];   // byte-addressed reference memory

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: byte-array memory, access rules from the ISA.
  function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                               input logic [2:0] f3, input logic [31:0] wd);
    int unsigned size;
    logic [31:0] v;
    if (f3 == 3 || f3 >= 6) return {1'b1, 32'h0};
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (addr / 4 >= DEPTH) return {1'b1, 32'h0};
    if (addr % size != 0) return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < int'(size); i++) mem_m[addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
      return {1'b0, 32'h0};
    end
    v = 0;
    for (int i = 0; i < int'(size); i++) v = v | (32'(mem_m[addr + i]) << (8 * i));
    if (f3 < 4 && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
      v = v | (32'hFFFF_FFFF << (8 * size));
    return {1'b0, v};
  endfunction

  // ---------------- driver ----------------
  task automatic junk_inputs();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'($urandom_range(0, WIN - 1) * 4);
    req_funct3 = 3'b010;
    req_wdata  = $urandom;
  endtask

  // Called #1 after a clock edge with the DUT idle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold);
    int cyc;
    logic [32:0] e;
    logic [31:0] d0;
    logic e0;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(model_access(we, addr, f3, wd));
    junk_inputs();  // must be ignored outside IDLE
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      check("req_ready_wait", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(LAT));
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    e = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, e[31:0]);
    check("rsp_err", 32'(rsp_err), 32'(e[32]));
    d0 = rsp_rdata; e0 = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, d0);
      check("hold_err", 32'(rsp_err), 32'(e0));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    check("consume_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    logic        w;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_funct3 = 3'b000; req_wdata = 32'h0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0);
    do_req(1'b0, 32'h10, 3'b010, 32'h0, 0);
    check("lw_10_const", rsp_rdata, 32'hDEADBEEF);
    do_req(1'b0, 32'h13, 3'b000, 32'h0, 0);
    check("lb_13_const", rsp_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 32'h13, 3'b100, 32'h0, 0);
    check("lbu_13_const", rsp_rdata, 32'h000000DE);
    do_req(1'b0, 32'h12, 3'b001, 32'h0, 0);
    check("lh_12_const", rsp_rdata, 32'hFFFFDEAD);
    do_req(1'b0, 32'h10, 3'b101, 32'h0, 5);
    check("lhu_10_const", rsp_rdata, 32'h0000BEEF);
    do_req(1'b1, 32'h11, 3'b001, 32'h1234, 0);
    check("sh_mis_err", 32'(rsp_err), 32'd1);
    do_req(1'b0, 32'h10, 3'b010, 32'h0, 0);
    check("word_intact", rsp_rdata, 32'hDEADBEEF);
    do_req(1'b0, 32'h12, 3'b010, 32'h0, 0);
    do_req(1'b0, 32'(DEPTH * 4), 3'b010, 32'h0, 0);
    do_req(1'b0, 32'h10, 3'b011, 32'h0, 0);
    do_req(1'b1, 32'hFFFF_FFF0, 3'b010, 32'h5, 0);

    // Give the random window known contents
    for (int i = 0; i < WIN; i++) do_req(1'b1, 32'(i * 4), 3'b010, $urandom, 0);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
        1:       a = $urandom;
        2, 3:    a = 32'($urandom_range(0, WIN * 4 - 1));
        default: a = 32'($urandom_range(0, WIN * 4 - 1)) & ~32'((f % 4 == 2) ? 3 : (f % 4 == 1) ? 1 : 0);
      endcase
      do_req(w, a, f, $urandom, $urandom_range(0, 3));
    end

    // Reset during WAIT of a load: no response, back to IDLE
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rdata", rsp_rdata, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Reset during WAIT of a store: the committed store remains
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    void'(model_access(1'b1, 32'h20, 3'b010, 32'hCAFEF00D));
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("strst_rsp_valid", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 32'h20, 3'b010, 32'h0, 0);
    check("store_survives", rsp_rdata, 32'hCAFEF00D);
    for (int i = 0; i < WIN; i++) do_req(1'b0, 32'(i * 4), 3'b010, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary.
  initial begin
    #2_000_000;
    n_checks++;
    $display("FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
